// File: rtl/fir_pkg.sv
// Shared constants for the FIR sequencer: default geometry, one-hot state
// encoding, FPALU opcodes and ALU A-source select codes.
package fir_pkg;

  localparam int NTAP_DEF    = 64;
  localparam int MUL_LAT_DEF = 4;
  localparam int ADD_LAT_DEF = 5;

  // Bit position matches the phase output: [0]LOAD .. [6]IDLE
  typedef enum logic [6:0] {
    S_LOAD     = 7'b000_0001,
    S_MUL      = 7'b000_0010,
    S_ACC_THRU = 7'b000_0100,
    S_ACC      = 7'b000_1000,
    S_NORM     = 7'b001_0000,
    S_DONE     = 7'b010_0000,
    S_IDLE     = 7'b100_0000
  } state_t;

  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b11;
  localparam logic [1:0] OP_ADDNORM = 2'b00;

  localparam logic [1:0] ASEL_DMEM = 2'b00;
  localparam logic [1:0] ASEL_SELF = 2'b01;
  localparam logic [1:0] ASEL_REGF = 2'b10;

endpackage

// File: rtl/fir_dly.sv
// Fixed-length 1-bit shift delay with synchronous reset; output is the input
// delayed by exactly N cycles.
module fir_dly
  import fir_pkg::*;
#(
  parameter int N = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= N'({sr, d});
  end

  assign q = sr[N-1];

endmodule

// File: rtl/fir_seq.sv
// Sequencer for a time-multiplexed FIR built around a pipelined FPALU.
// state    | meaning
// IDLE     | wait for sample_vld; coefficient writes may be granted
// LOAD     | write din into the data ring at wptr
// MUL      | issue NTAP multiplies, coefficient k against sample base-k
// ACC_THRU | first ADD_LAT adds feed the ALU result back to itself
// ACC      | fold remaining products from the register file
// NORM     | normalising add, then drain the add pipeline
// DONE     | one-cycle dout_vld
module fir_seq
  import fir_pkg::*;
#(
  parameter int NTAP    = NTAP_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                    clk2,
  input  logic                    rst,
  input  logic                    sample_vld,
  input  logic                    cload_req,
  output logic                    cload_gnt,
  output logic [6:0]              phase,
  output logic                    alu_en,
  output logic [1:0]              alu_opcode,
  output logic [1:0]              asel,
  output logic                    dmem_we,
  output logic [$clog2(NTAP)-1:0] dmem_addr,
  output logic [$clog2(NTAP)-1:0] cmem_addr,
  output logic                    regf_we,
  output logic [$clog2(NTAP)-1:0] regf_waddr,
  output logic [$clog2(NTAP)-1:0] regf_raddr,
  output logic                    dout_vld,
  output logic                    overrun
);

  localparam int AW = $clog2(NTAP);
  localparam int CW = $clog2(2*NTAP);

  localparam logic [CW-1:0] MUL_LD  = CW'(NTAP-1);
  localparam logic [CW-1:0] THRU_LD = CW'(ADD_LAT-1);
  localparam logic [CW-1:0] ACC_LD  = CW'(NTAP-ADD_LAT-1);
  localparam logic [CW-1:0] NORM_LD = CW'(ADD_LAT-1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;
  logic          mul_issue;

  assign phase     = state;
  assign mul_issue = alu_en && (state == S_MUL);
  // A sample arriving in the same IDLE cycle takes priority over a coefficient write
  assign cload_gnt = (state == S_IDLE) && cload_req && !sample_vld;

  fir_dly #(.N(MUL_LAT)) u_dly (
    .clk (clk2),
    .rst (rst),
    .d   (mul_issue),
    .q   (regf_we)
  );

  always_ff @(posedge clk2) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wptr       <= '0;
      base       <= '0;
      dmem_addr  <= '0;
      cmem_addr  <= '0;
      regf_waddr <= '0;
      regf_raddr <= '0;
      alu_en     <= 1'b0;
      alu_opcode <= OP_ADDNORM;
      asel       <= ASEL_DMEM;
      dmem_we    <= 1'b0;
      dout_vld   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sample_vld && (state != S_IDLE)) overrun <= 1'b1;

      if (state == S_LOAD)  regf_waddr <= '0;
      else if (regf_we)     regf_waddr <= regf_waddr + 1'b1;

      unique case (state)
        S_IDLE: begin
          if (sample_vld) begin
            state     <= S_LOAD;
            base      <= wptr;
            dmem_we   <= 1'b1;
            dmem_addr <= wptr;
          end
        end
        S_LOAD: begin
          state      <= S_MUL;
          cnt        <= MUL_LD;
          wptr       <= wptr + 1'b1;
          dmem_we    <= 1'b0;
          alu_en     <= 1'b1;
          alu_opcode <= OP_MUL;
          asel       <= ASEL_DMEM;
          cmem_addr  <= '0;
          dmem_addr  <= base;
        end
        S_MUL: begin
          if (cnt == '0) begin
            state      <= S_ACC_THRU;
            cnt        <= THRU_LD;
            alu_opcode <= OP_ADD;
            asel       <= ASEL_SELF;
          end else begin
            cnt       <= cnt - 1'b1;
            cmem_addr <= cmem_addr + 1'b1;
            dmem_addr <= dmem_addr - 1'b1;
          end
        end
        S_ACC_THRU: begin
          if (cnt == '0) begin
            state      <= S_ACC;
            cnt        <= ACC_LD;
            asel       <= ASEL_REGF;
            regf_raddr <= AW'(ADD_LAT);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACC: begin
          if (cnt == '0) begin
            state      <= S_NORM;
            cnt        <= NORM_LD;
            alu_opcode <= OP_ADDNORM;
            asel       <= ASEL_REGF;
          end else begin
            cnt        <= cnt - 1'b1;
            regf_raddr <= regf_raddr + 1'b1;
          end
        end
        S_NORM: begin
          if (cnt == '0) begin
            state      <= S_DONE;
            alu_en     <= 1'b0;
            alu_opcode <= OP_ADDNORM;
            asel       <= ASEL_DMEM;
            dout_vld   <= 1'b1;
          end else begin
            cnt  <= cnt - 1'b1;
            asel <= ASEL_DMEM;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          dout_vld <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq at default parameters: per-cycle expectations
// derived from the documented cycle map of one filter pass.
module tb_fir_seq;

  logic       clk2 = 1'b0;
  logic       rst = 1'b1;
  logic       sample_vld = 1'b0;
  logic       cload_req = 1'b0;
  logic       cload_gnt;
  logic [6:0] phase;
  logic       alu_en;
  logic [1:0] alu_opcode;
  logic [1:0] asel;
  logic       dmem_we;
  logic [5:0] dmem_addr;
  logic [5:0] cmem_addr;
  logic       regf_we;
  logic [5:0] regf_waddr;
  logic [5:0] regf_raddr;
  logic       dout_vld;
  logic       overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  bit ovr_exp = 1'b0;

  always #5 clk2 = ~clk2;

  fir_seq dut (
    .clk2       (clk2),
    .rst        (rst),
    .sample_vld (sample_vld),
    .cload_req  (cload_req),
    .cload_gnt  (cload_gnt),
    .phase      (phase),
    .alu_en     (alu_en),
    .alu_opcode (alu_opcode),
    .asel       (asel),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .cmem_addr  (cmem_addr),
    .regf_we    (regf_we),
    .regf_waddr (regf_waddr),
    .regf_raddr (regf_raddr),
    .dout_vld   (dout_vld),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Current cycle is "cycle 0": the sample strobe is raised here.
  // Cycle map: LOAD 1, MUL 2..65, ACC_THRU 66..70, ACC 71..129, NORM 130..134, DONE 135.
  task automatic run_frame(input int b, input bit poke, input int last);
    sample_vld = 1'b1;
    #1;
    chk("gnt_c0", cload_gnt, 0);
    tick();
    sample_vld = 1'b0;
    chk("load_phase", phase, 7'h01);
    chk("load_we", dmem_we, 1);
    chk("load_addr", dmem_addr, b);
    chk("load_alu_en", alu_en, 0);
    for (int c = 2; c <= last; c++) begin
      int ph;
      int en;
      int op;
      int as;
      int rwe;
      tick();
      sample_vld = 1'b0;
      if (poke && c == 101) ovr_exp = 1'b1;
      if (c <= 65)       begin ph = 2;  en = 1; op = 2; as = 0; end
      else if (c <= 70)  begin ph = 4;  en = 1; op = 3; as = 1; end
      else if (c <= 129) begin ph = 8;  en = 1; op = 3; as = 2; end
      else if (c <= 134) begin ph = 16; en = 1; op = 0; as = (c == 130) ? 2 : 0; end
      else if (c == 135) begin ph = 32; en = 0; op = 0; as = 0; end
      else               begin ph = 64; en = 0; op = 0; as = 0; end
      rwe = (c >= 6 && c <= 69) ? 1 : 0;
      chk("phase", phase, ph);
      chk("alu_en", alu_en, en);
      chk("alu_opcode", alu_opcode, op);
      chk("asel", asel, as);
      chk("dmem_we", dmem_we, 0);
      chk("dout_vld", dout_vld, (c == 135) ? 1 : 0);
      chk("regf_we", regf_we, rwe);
      chk("overrun", overrun, ovr_exp);
      chk("cload_gnt", cload_gnt, (cload_req && c >= 136) ? 1 : 0);
      if (c <= 65) begin
        chk("mul_dmem_addr", dmem_addr, (b - (c - 2)) & 63);
        chk("mul_cmem_addr", cmem_addr, c - 2);
      end
      if (rwe == 1) chk("regf_waddr", regf_waddr, c - 6);
      if (c >= 71 && c <= 129) chk("regf_raddr", regf_raddr, 5 + c - 71);
      if (poke && c == 100) sample_vld = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_phase", phase, 7'h40);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_regf_we", regf_we, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_asel", asel, 0);

    // First sample on the first cycle with rst low
    rst = 1'b0;
    run_frame(0, 1'b0, 136);

    // Second pass: base 1, overrun injected during ACC
    run_frame(1, 1'b1, 136);

    // Coefficient request collides with a sample, then is granted after DONE
    cload_req = 1'b1;
    run_frame(2, 1'b0, 136);
    cload_req = 1'b0;

    // Reset mid-MUL at k=30 (cycle 32)
    run_frame(3, 1'b0, 32);
    rst = 1'b1;
    tick();
    ovr_exp = 1'b0;
    chk("mid_rst_phase", phase, 7'h40);
    chk("mid_rst_alu_en", alu_en, 0);
    chk("mid_rst_dmem_we", dmem_we, 0);
    chk("mid_rst_regf_we", regf_we, 0);
    chk("mid_rst_dout_vld", dout_vld, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    run_frame(0, 1'b0, 136);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
